ser_tx_scheduler: RTL and testbench

//  Round-robin scheduler for the 27-bit serializer: shares it among NREQ requesters.
//  Per transfer: picks one pending request, loads its word and pulses start, then

---
 rtl/ser_tx_scheduler.sv | 175 +++++++++++++++++
 tb/tb_ser_tx_scheduler.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ser_tx_scheduler.sv
// Round-robin scheduler sharing one 27-bit serializer among NREQ requesters,
// with a programmable inter-frame gap and a sticky start-to-busy timeout flag.
module ser_tx_scheduler #(
  parameter int NREQ    = 2,
  parameter int DW      = 27,
  parameter int GAP     = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NREQ-1:0]      req_i,
  input  logic [NREQ*DW-1:0]   data_i,
  output logic [NREQ-1:0]      ack_o,
  output logic [NREQ-1:0]      done_o,
  output logic                 ser_start_o,
  output logic [DW-1:0]        ser_data_o,
  input  logic                 ser_ena_i,
  output logic                 busy_o,
  output logic                 err_o,
  input  logic                 err_clr_i
);
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CMAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 2);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP > 0) ? GAP - 1 : 0);
  localparam bit            HAS_GAP  = (GAP > 0);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_ENA  = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_GAP       = 3'd4
  } state_e;

  state_e          state_r;
  logic [PW-1:0]   ptr_r;
  logic [CW-1:0]   cnt_r;
  logic [NREQ-1:0] ack_r;
  logic [NREQ-1:0] done_r;
  logic            start_r;
  logic [DW-1:0]   data_r;
  logic            busy_r;
  logic            err_r;

  logic [PW-1:0]   pick_s;
  logic            found_s;
  logic            timeout_s;
  logic            err_next_s;

  function automatic logic [PW-1:0] rr_next(input logic [PW-1:0] idx);
    logic [PW-1:0] nxt;
    if (idx == LAST_IDX) begin
      nxt = {PW{1'b0}};
    end else begin
      nxt = idx + PW'(1);
    end
    return nxt;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] idx);
    return {{(NREQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  // first pending request strictly after the round-robin pointer, wrapping
  always_comb begin : pick_blk
    logic [PW-1:0] scan;
    scan    = ptr_r;
    pick_s  = ptr_r;
    found_s = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      scan = rr_next(scan);
      if (!found_s && req_i[scan]) begin
        pick_s  = scan;
        found_s = 1'b1;
      end else begin
        pick_s  = pick_s;
        found_s = found_s;
      end
    end
  end

  // timeout fires on the last allowed WAIT_ENA cycle that still sees no ena
  assign timeout_s = (state_r == S_WAIT_ENA) && !ser_ena_i && (cnt_r == TO_LAST);

  // sticky error: a new timeout beats a clear in the same cycle
  always_comb begin
    if (timeout_s) begin
      err_next_s = 1'b1;
    end else if (err_clr_i) begin
      err_next_s = 1'b0;
    end else begin
      err_next_s = err_r;
    end
  end

  // transfer FSM with registered grant, start, done and busy outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= S_IDLE;
      ptr_r   <= LAST_IDX;
      cnt_r   <= {CW{1'b0}};
      ack_r   <= {NREQ{1'b0}};
      done_r  <= {NREQ{1'b0}};
      start_r <= 1'b0;
      data_r  <= {DW{1'b0}};
      busy_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      ack_r   <= {NREQ{1'b0}};
      done_r  <= {NREQ{1'b0}};
      start_r <= 1'b0;
      err_r   <= err_next_s;
      case (state_r)
        S_IDLE: begin
          if (found_s) begin
            data_r  <= data_i[int'(pick_s) * DW +: DW];
            ack_r   <= onehot(pick_s);
            start_r <= 1'b1;
            ptr_r   <= pick_s;
            busy_r  <= 1'b1;
            state_r <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          cnt_r   <= {CW{1'b0}};
          state_r <= S_WAIT_ENA;
        end
        S_WAIT_ENA: begin
          if (ser_ena_i) begin
            state_r <= S_WAIT_DONE;
          end else if (timeout_s) begin
            done_r  <= onehot(ptr_r);
            cnt_r   <= {CW{1'b0}};
            busy_r  <= HAS_GAP;
            state_r <= HAS_GAP ? S_GAP : S_IDLE;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        S_WAIT_DONE: begin
          if (!ser_ena_i) begin
            done_r  <= onehot(ptr_r);
            cnt_r   <= {CW{1'b0}};
            busy_r  <= HAS_GAP;
            state_r <= HAS_GAP ? S_GAP : S_IDLE;
          end
        end
        S_GAP: begin
          if (cnt_r == GAP_LAST) begin
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b0;
            state_r <= S_IDLE;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign ack_o       = ack_r;
  assign done_o      = done_r;
  assign ser_start_o = start_r;
  assign ser_data_o  = data_r;
  assign busy_o      = busy_r;
  assign err_o       = err_r;

endmodule

// File: tb/tb_ser_tx_scheduler.sv
// Scoreboard bench for ser_tx_scheduler: main instance (GAP=4) plus a GAP=0
// instance for back-to-back grants.
`timescale 1ns/1ps
module tb_ser_tx_scheduler;
  localparam int NREQ    = 2;
  localparam int DW      = 27;
  localparam int GAP     = 4;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NREQ-1:0] req, ack, done;
  logic [DW-1:0]   d0, d1, ser_data;
  logic            start, ser_ena, busy, err, err_clr;

  logic [NREQ-1:0] req2, ack2, done2;
  logic [DW-1:0]   d2_0, d2_1, sdata2;
  logic            start2, ena2, busy2, err2;

  ser_tx_scheduler #(.NREQ(NREQ), .DW(DW), .GAP(GAP), .TIMEOUT(TIMEOUT)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .data_i({d1, d0}),
    .ack_o(ack), .done_o(done), .ser_start_o(start), .ser_data_o(ser_data),
    .ser_ena_i(ser_ena), .busy_o(busy), .err_o(err), .err_clr_i(err_clr)
  );

  ser_tx_scheduler #(.NREQ(NREQ), .DW(DW), .GAP(0), .TIMEOUT(TIMEOUT)) u_gap0 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req2), .data_i({d2_1, d2_0}),
    .ack_o(ack2), .done_o(done2), .ser_start_o(start2), .ser_data_o(sdata2),
    .ser_ena_i(ena2), .busy_o(busy2), .err_o(err2), .err_clr_i(1'b0)
  );

  typedef struct packed {
    logic [NREQ-1:0] ack;
    logic [DW-1:0]   data;
  } grant_t;

  grant_t          exp_q[$];
  logic [NREQ-1:0] done_q[$];

  int n_checks  = 0;
  int n_errors  = 0;
  int cyc       = 0;
  int last_done = -1000;
  bit ena_auto  = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got 0x%0h with empty scoreboard", name, act);
  endtask

  task automatic wait_ack(input int n, input int budget);
    int seen;
    seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ack != '0) seen++;
      if (seen == n) return;
    end
    chk("ack wait timeout", 64'(seen), 64'(n));
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    chk("idle wait timeout", 64'(busy), 64'd0);
  endtask

  // serializer model: ena rises the cycle after start and stays up 27 cycles
  initial begin
    ser_ena = 1'b0;
    forever begin
      @(negedge clk);
      if (ena_auto && start) begin
        @(negedge clk);
        ser_ena = 1'b1;
        repeat (27) @(negedge clk);
        ser_ena = 1'b0;
      end
    end
  end

  // monitor: every start/done pulse pops and checks the next expected entry
  initial begin
    grant_t          e;
    logic [NREQ-1:0] ed;
    forever begin
      @(negedge clk);
      cyc = cyc + 1;
      if (rst_n) begin
        if (start) begin
          if (exp_q.size() == 0) begin
            unexpected("unexpected start", 64'(ack));
          end else begin
            e = exp_q.pop_front();
            chk("grant ack", 64'(ack), 64'(e.ack));
            chk("grant data", 64'(ser_data), 64'(e.data));
            chk("gap before start", 64'(cyc - last_done >= GAP + 1), 64'd1);
          end
        end
        if (done != '0) begin
          last_done = cyc;
          if (done_q.size() == 0) begin
            unexpected("unexpected done", 64'(done));
          end else begin
            ed = done_q.pop_front();
            chk("done requester", 64'(done), 64'(ed));
          end
        end
      end
    end
  end

  initial begin
    int k;
    bit found;
    int nstart;
    rst_n = 1'b0; req = '0; d0 = '0; d1 = '0; err_clr = 1'b0;
    req2 = '0; d2_0 = '0; d2_1 = '0; ena2 = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    chk("reset ack", 64'(ack), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset start", 64'(start), 64'd0);
    chk("reset data", 64'(ser_data), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset err", 64'(err), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // fairness: both held, expect 0,1,0,1
    d0 = 27'h1111111; d1 = 27'h2222222;
    req = 2'b11;
    exp_q.push_back('{2'b01, 27'h1111111}); exp_q.push_back('{2'b10, 27'h2222222});
    exp_q.push_back('{2'b01, 27'h1111111}); exp_q.push_back('{2'b10, 27'h2222222});
    done_q.push_back(2'b01); done_q.push_back(2'b10);
    done_q.push_back(2'b01); done_q.push_back(2'b10);
    wait_ack(4, 400);
    req = 2'b00;
    wait_idle(100);

    // single request: start one cycle after req, done 29 cycles after start
    d0 = 27'h5A5A5A5; req = 2'b01;
    exp_q.push_back('{2'b01, 27'h5A5A5A5}); done_q.push_back(2'b01);
    @(negedge clk);
    chk("t1 start latency", 64'(start), 64'd1);
    chk("t1 ack", 64'(ack), 64'd1);
    req = 2'b00;
    k = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (done != '0) begin k = i; break; end
    end
    chk("t1 start to done", 64'(k), 64'd29);
    wait_idle(20);

    // timeout: ena never rises
    ena_auto = 1'b0;
    d1 = 27'h1234567; req = 2'b10;
    exp_q.push_back('{2'b10, 27'h1234567}); done_q.push_back(2'b10);
    @(negedge clk);
    chk("t3 start", 64'(start), 64'd1);
    req = 2'b00;
    repeat (15) @(negedge clk);
    chk("t3 err before limit", 64'(err), 64'd0);
    @(negedge clk);
    chk("t3 err at limit", 64'(err), 64'd1);
    chk("t3 abort done", 64'(done), 64'd2);
    ena_auto = 1'b1;
    wait_idle(20);
    d0 = 27'h7654321; req = 2'b01;
    exp_q.push_back('{2'b01, 27'h7654321}); done_q.push_back(2'b01);
    wait_ack(1, 20);
    req = 2'b00;
    wait_idle(100);
    chk("t3 err sticky", 64'(err), 64'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("t3 err cleared", 64'(err), 64'd0);

    // reset mid-WAIT_DONE
    d1 = 27'h3C3C3C3; req = 2'b10;
    exp_q.push_back('{2'b10, 27'h3C3C3C3});
    @(negedge clk);
    req = 2'b00;
    repeat (10) @(negedge clk);
    chk("t4 busy before reset", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t4 rst start", 64'(start), 64'd0);
    chk("t4 rst ack", 64'(ack), 64'd0);
    chk("t4 rst done", 64'(done), 64'd0);
    chk("t4 rst busy", 64'(busy), 64'd0);
    chk("t4 rst data", 64'(ser_data), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    d0 = 27'h0F0F0F0; req = 2'b11;
    exp_q.push_back('{2'b01, 27'h0F0F0F0}); done_q.push_back(2'b01);
    wait_ack(1, 20);
    chk("t4 grant after reset", 64'(ack), 64'd1);
    req = 2'b00;
    wait_idle(100);

    // GAP=0 instance: back-to-back re-grant, dropped request not granted
    d2_1 = 27'h0ABCDEF; req2 = 2'b10;
    @(negedge clk);
    chk("t5 first start", 64'(start2), 64'd1);
    chk("t5 first ack", 64'(ack2), 64'd2);
    chk("t5 data", 64'(sdata2), 64'h0ABCDEF);
    ena2 = 1'b1;
    repeat (3) @(negedge clk);
    ena2 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done2 != '0) begin found = 1'b1; break; end
    end
    chk("t5 done seen", 64'(found), 64'd1);
    chk("t5 done", 64'(done2), 64'd2);
    @(negedge clk);
    chk("t5 back-to-back start", 64'(start2), 64'd1);
    chk("t5 back-to-back ack", 64'(ack2), 64'd2);
    req2 = 2'b01;
    @(negedge clk);
    req2 = 2'b00;
    ena2 = 1'b1;
    repeat (3) @(negedge clk);
    ena2 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done2 != '0) begin found = 1'b1; break; end
    end
    chk("t5 second done seen", 64'(found), 64'd1);
    nstart = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (start2) nstart++;
    end
    chk("t5 dropped req not granted", 64'(nstart), 64'd0);
    chk("t5 idle", 64'(busy2), 64'd0);
    chk("t5 no err", 64'(err2), 64'd0);

    repeat (5) @(negedge clk);
    chk("grant scoreboard drained", 64'(exp_q.size()), 64'd0);
    chk("done scoreboard drained", 64'(done_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
